usb_rx_block_assembler: RTL

- Byte-stream stage directly downstream of the USB receive path's byte output; upstream of the AES core.
- Strips and validates the PID, checks CRC16, and packs payload bytes into 128-bit blocks for the AES engine.
- Reports a per-packet status.

---
 rtl/usb_rx_block_assembler_if.sv | 22 ++
 rtl/usb_rx_block_assembler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_block_assembler_if.sv
// rtl/usb_rx_block_assembler_if.sv - 128-bit block handshake channel from the USB rx assembler to the AES core
// Purpose: carries assembled payload blocks with a valid/ready handshake.
// Signals: block_data (first payload byte in [127:120]), block_valid, block_ready,
//          block_last (final block of a packet), block_nbytes (1..16 valid bytes).
// Modports: master = block producer (assembler), slave = block consumer (AES side).
interface usb_rx_block_assembler_if;
   logic [127:0] block_data;
   logic         block_valid;
   logic         block_ready;
   logic         block_last;
   logic [4:0]   block_nbytes;

   modport master (
      output block_data, block_valid, block_last, block_nbytes,
      input  block_ready
   );

   modport slave (
      input  block_data, block_valid, block_last, block_nbytes,
      output block_ready
   );
endinterface

// File: rtl/usb_rx_block_assembler.sv
// rtl/usb_rx_block_assembler.sv - PID/CRC16 checker and 128-bit block packer for USB receive data
// Purpose: validates the DATA0/DATA1 PID, strips the trailing CRC16 through a 2-byte delay
//          line, checks it, packs payload into 16-byte blocks and reports per-packet status.
// Ports:   clk, rst (sync, active-high)
//          rx_byte_i, rx_byte_valid_i, rx_eop_i, rx_err_i - unstallable byte stream in
//          blk (master) - block_data/valid/ready/last/nbytes out
//          pkt_pid_data1_o, pkt_done_o, pkt_status_o - per-packet status pulse
//          (00 ok, 01 CRC, 10 PID, 11 overrun/overflow/rx_err)
// Option:  define USB_RX_TOGGLE_CHECK_EN to enforce DATA0/DATA1 toggle sequencing.
module usb_rx_block_assembler #(
   parameter int MAX_DATA    = 64,
   parameter int BLOCK_BYTES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte_i,
   input  logic       rx_byte_valid_i,
   input  logic       rx_eop_i,
   input  logic       rx_err_i,
   usb_rx_block_assembler_if.master blk,
   output logic       pkt_pid_data1_o,
   output logic       pkt_done_o,
   output logic [1:0] pkt_status_o
);

   typedef enum logic [2:0] {S_IDLE, S_DATA, S_CHECK, S_FLUSH, S_DROP} state_t;

   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [4:0] FILL_FULL = 5'(BLOCK_BYTES);
   localparam logic [6:0] COUNT_MAX = 7'(MAX_DATA);
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_CRC  = 2'b01;
   localparam logic [1:0] ST_PID  = 2'b10;
   localparam logic [1:0] ST_DROP = 2'b11;

   state_t        state_q, state_d;
   logic [1:0]    status_q, status_d;
   logic          pid1_q, pid1_d;
   logic [7:0]    line0_q, line0_d;   // older byte of the delay line
   logic [7:0]    line1_q, line1_d;
   logic [1:0]    line_cnt_q, line_cnt_d;
   logic [15:0]   crc_q, crc_d;
   logic [127:0]  fill_q, fill_d;
   logic [4:0]    fill_cnt_q, fill_cnt_d;
   logic [6:0]    count_q, count_d;
   logic [127:0]  out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [4:0]    out_nbytes_q, out_nbytes_d;
   logic          overrun_q, overrun_d;

   logic          done;
   logic [1:0]    done_status;
   logic          fail;
   logic [1:0]    fail_status;
   logic [3:0]    fill_idx;
   logic [127:0]  fill_base;
   logic          out_free;
   logic          pid_ok;
   logic          toggle_mismatch;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   assign pid_ok = (rx_byte_i[7:4] == ~rx_byte_i[3:0]) &&
                   ((rx_byte_i == PID_DATA0) || (rx_byte_i == PID_DATA1));
   // A slot being consumed this edge may be reloaded in the same edge.
   assign out_free = !out_valid_q || blk.block_ready;

`ifdef USB_RX_TOGGLE_CHECK_EN
   logic toggle_q, toggle_d;
   assign toggle_mismatch = ((rx_byte_i == PID_DATA1) != toggle_q);
   always_comb begin
      toggle_d = toggle_q;
      if (done && (done_status == ST_OK)) toggle_d = ~toggle_q;
   end
   always_ff @(posedge clk) begin
      if (rst) toggle_q <= 1'b0;
      else     toggle_q <= toggle_d;
   end
`else
   assign toggle_mismatch = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      status_d     = status_q;
      pid1_d       = pid1_q;
      line0_d      = line0_q;
      line1_d      = line1_q;
      line_cnt_d   = line_cnt_q;
      crc_d        = crc_q;
      fill_d       = fill_q;
      fill_cnt_d   = fill_cnt_q;
      count_d      = count_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_nbytes_d = out_nbytes_q;
      overrun_d    = overrun_q;
      done         = 1'b0;
      done_status  = ST_OK;
      fail         = 1'b0;
      fail_status  = ST_OK;
      fill_idx     = 4'd0;
      fill_base    = fill_q;

      if (out_valid_q && blk.block_ready) out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_byte_valid_i) begin
               pid1_d     = (rx_byte_i == PID_DATA1);
               line_cnt_d = 2'd0;
               crc_d      = 16'hFFFF;
               fill_d     = '0;
               fill_cnt_d = 5'd0;
               count_d    = 7'd0;
               if (!pid_ok || toggle_mismatch) begin
                  fail        = 1'b1;
                  fail_status = ST_PID;
               end else if (overrun_q) begin
                  // A byte was lost during the previous flush; this packet pays for it.
                  fail        = 1'b1;
                  fail_status = ST_DROP;
                  overrun_d   = 1'b0;
               end else if (rx_eop_i) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_err_i) begin
               fail        = 1'b1;
               fail_status = ST_DROP;
            end else begin
               if (rx_byte_valid_i) begin
                  if (line_cnt_q == 2'd2) begin
                     // Oldest byte leaves the delay line and becomes payload.
                     if (count_q == COUNT_MAX) begin
                        fail        = 1'b1;
                        fail_status = ST_DROP;
                     end else if ((fill_cnt_q == FILL_FULL) && !out_free) begin
                        fail        = 1'b1;
                        fail_status = ST_DROP;
                     end else begin
                        if (fill_cnt_q == FILL_FULL) begin
                           out_data_d   = fill_q;
                           out_valid_d  = 1'b1;
                           out_last_d   = 1'b0;
                           out_nbytes_d = FILL_FULL;
                           fill_base    = '0;
                           fill_idx     = 4'd0;
                        end else begin
                           fill_idx = fill_cnt_q[3:0];
                        end
                        fill_d = fill_base;
                        fill_d[(15 - int'(fill_idx)) * 8 +: 8] = line0_q;
                        fill_cnt_d = {1'b0, fill_idx} + 5'd1;
                        count_d    = count_q + 7'd1;
                        crc_d      = crc16_byte(crc_q, line0_q);
                     end
                     line0_d = line1_q;
                     line1_d = rx_byte_i;
                  end else if (line_cnt_q == 2'd1) begin
                     line1_d    = rx_byte_i;
                     line_cnt_d = 2'd2;
                  end else begin
                     line0_d    = rx_byte_i;
                     line_cnt_d = 2'd1;
                  end
               end
               if (!fail && rx_eop_i) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (rx_err_i) begin
               fail        = 1'b1;
               fail_status = ST_DROP;
            end else if ((line_cnt_q != 2'd2) || ({line1_q, line0_q} != ~crc_q)) begin
               done        = 1'b1;
               done_status = ST_CRC;
               state_d     = S_IDLE;
            end else if (fill_cnt_q == 5'd0) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (rx_err_i) begin
               fail        = 1'b1;
               fail_status = ST_DROP;
            end else begin
               if (rx_byte_valid_i) overrun_d = 1'b1;
               if (out_free) begin
                  out_data_d   = fill_q;
                  out_valid_d  = 1'b1;
                  out_last_d   = 1'b1;
                  out_nbytes_d = fill_cnt_q;
                  done         = 1'b1;
                  state_d      = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (rx_err_i) begin
               fail        = 1'b1;
               fail_status = ST_DROP;
            end else if (rx_eop_i) begin
               done        = 1'b1;
               done_status = status_q;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An error coinciding with eop completes the packet immediately.
      if (fail) begin
         if (rx_eop_i) begin
            done        = 1'b1;
            done_status = fail_status;
            state_d     = S_IDLE;
         end else begin
            state_d  = S_DROP;
            status_d = fail_status;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         status_q     <= 2'b00;
         pid1_q       <= 1'b0;
         line0_q      <= 8'h00;
         line1_q      <= 8'h00;
         line_cnt_q   <= 2'd0;
         crc_q        <= 16'hFFFF;
         fill_q       <= '0;
         fill_cnt_q   <= 5'd0;
         count_q      <= 7'd0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_nbytes_q <= 5'd0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         status_q     <= status_d;
         pid1_q       <= pid1_d;
         line0_q      <= line0_d;
         line1_q      <= line1_d;
         line_cnt_q   <= line_cnt_d;
         crc_q        <= crc_d;
         fill_q       <= fill_d;
         fill_cnt_q   <= fill_cnt_d;
         count_q      <= count_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_nbytes_q <= out_nbytes_d;
         overrun_q    <= overrun_d;
      end
   end

   assign blk.block_data   = out_data_q;
   assign blk.block_valid  = out_valid_q;
   assign blk.block_last   = out_last_q;
   assign blk.block_nbytes = out_nbytes_q;
   assign pkt_done_o       = done;
   assign pkt_status_o     = done_status;
   assign pkt_pid_data1_o  = done & pid1_q;

endmodule
